// File: rtl/sprite_render_pkg.sv
// Shared PPU constants for the sprite slot: SPR_BUF field offsets, attribute bits
// and the visible-line width, plus the pattern bit-select helper.
package sprite_render_pkg;

    localparam int SPR_BUF_W   = 32;
    localparam int PIXEL_X_W   = 10;

    localparam int BUF_LSB     = 0;
    localparam int BUF_MSB     = 8;
    localparam int BUF_XPOS    = 16;
    localparam int BUF_ATTR    = 24;

    localparam int ATTR_HFLIP  = 6;
    localparam int ATTR_VFLIP  = 7;
    localparam int ATTR_PRIO   = 5;
    localparam int ATTR_PAL_HI = 1;
    localparam int ATTR_PAL_LO = 0;

    localparam int X_VISIBLE   = 256;
    localparam logic [PIXEL_X_W-1:0] X_VISIBLE_COL = 10'd256;

    // Pattern bytes hold the leftmost pixel in bit 7; hflip mirrors that order.
    function automatic logic [2:0] sprite_bit_index(input logic [2:0] col,
                                                    input logic       hflip);
        logic [2:0] idx;
        if (hflip) begin
            idx = col;
        end else begin
            idx = 3'd7 - col;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sprite_render_if.sv
// Loader/multiplexer side of one sprite slot: record input, pixel column,
// load/draw strobes and the palette/opacity result.
interface sprite_render_if;
    import sprite_render_pkg::*;

    logic [SPR_BUF_W-1:0] SPR_BUF;
    logic [PIXEL_X_W-1:0] PIXEL_X;
    logic                 LOAD;
    logic                 DRAW_EN;
    logic [3:0]           PAL_COLOUR;
    logic                 VALID;

    modport master (
        output SPR_BUF, PIXEL_X, LOAD, DRAW_EN,
        input  PAL_COLOUR, VALID
    );

    modport slave (
        input  SPR_BUF, PIXEL_X, LOAD, DRAW_EN,
        output PAL_COLOUR, VALID
    );
endinterface

// File: rtl/sprite_render.sv
// One NES sprite slot: holds the scanline's pattern slice, X and attribute and
// reports, combinationally per column, whether the sprite paints an opaque pixel.
module sprite_render
    import sprite_render_pkg::*;
(
    input  logic            PPU_SLOW_CLOCK,
    input  logic            RST_N,
    sprite_render_if.slave  bus
);

    logic [7:0]           pat_lo_r;
    logic [7:0]           pat_hi_r;
    logic [7:0]           xpos_r;
    logic [7:0]           attr_r;
    logic                 active_r;

    logic [PIXEL_X_W-1:0] xpos_ext_s;
    logic [PIXEL_X_W-1:0] col_s;
    logic                 in_range_s;
    logic [2:0]           bit_idx_s;
    logic [1:0]           pix_s;
    logic                 valid_s;
    logic [3:0]           pal_s;
    logic                 unused_attr_s;

    // Slot record capture on LOAD; active follows DRAW_EN every edge.
    always_ff @(posedge PPU_SLOW_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            pat_lo_r <= 8'h00;
            pat_hi_r <= 8'h00;
            xpos_r   <= 8'h00;
            attr_r   <= 8'h00;
            active_r <= 1'b0;
        end else begin
            if (bus.LOAD) begin
                pat_lo_r <= bus.SPR_BUF[BUF_LSB  +: 8];
                pat_hi_r <= bus.SPR_BUF[BUF_MSB  +: 8];
                xpos_r   <= bus.SPR_BUF[BUF_XPOS +: 8];
                attr_r   <= bus.SPR_BUF[BUF_ATTR +: 8];
            end else begin
                pat_lo_r <= pat_lo_r;
                pat_hi_r <= pat_hi_r;
                xpos_r   <= xpos_r;
                attr_r   <= attr_r;
            end
            active_r <= bus.DRAW_EN;
        end
    end

    // Column decode and pixel lookup; no wrap past the visible line, so a
    // sprite near the right edge is simply clipped.
    always_comb begin
        xpos_ext_s = {2'b00, xpos_r};
        col_s      = bus.PIXEL_X - xpos_ext_s;
        in_range_s = (bus.PIXEL_X >= xpos_ext_s) &&
                     (col_s <= 10'd7) &&
                     (bus.PIXEL_X < X_VISIBLE_COL);
        bit_idx_s  = sprite_bit_index(col_s[2:0], attr_r[ATTR_HFLIP]);
        pix_s      = {pat_hi_r[bit_idx_s], pat_lo_r[bit_idx_s]};
        valid_s    = active_r & in_range_s & (pix_s != 2'b00);
        if (valid_s) begin
            pal_s = {attr_r[ATTR_PAL_HI:ATTR_PAL_LO], pix_s};
        end else begin
            pal_s = 4'h0;
        end
    end

    // Vertical flip is applied by the loader and priority by the multiplexer.
    assign unused_attr_s  = ^{attr_r[ATTR_VFLIP], attr_r[ATTR_PRIO:2]};

    assign bus.VALID      = valid_s;
    assign bus.PAL_COLOUR = pal_s;

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for one sprite slot: reset, basic draw, transparency, hflip,
// right-edge clip, DRAW_EN drop and reload with hand-computed expectations.
module tb_sprite_render;

    logic PPU_SLOW_CLOCK;
    logic RST_N;
    int   checks;
    int   errors;
    logic [3:0] exp_pal;
    logic       exp_valid;

    sprite_render_if bus();

    sprite_render dut (
        .PPU_SLOW_CLOCK (PPU_SLOW_CLOCK),
        .RST_N          (RST_N),
        .bus            (bus)
    );

    initial PPU_SLOW_CLOCK = 1'b0;
    always #5 PPU_SLOW_CLOCK = ~PPU_SLOW_CLOCK;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_record(input logic [31:0] rec);
        @(negedge PPU_SLOW_CLOCK);
        bus.SPR_BUF = rec;
        bus.LOAD    = 1'b1;
        bus.DRAW_EN = 1'b1;
        @(negedge PPU_SLOW_CLOCK);
        bus.LOAD    = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        RST_N       = 1'b0;
        bus.SPR_BUF = 32'h0000_0000;
        bus.PIXEL_X = 10'd0;
        bus.LOAD    = 1'b0;
        bus.DRAW_EN = 1'b0;
        repeat (2) @(negedge PPU_SLOW_CLOCK);
        #1;
        check("reset_valid", {3'b000, bus.VALID}, 4'h0);
        check("reset_pal", bus.PAL_COLOUR, 4'h0);
        RST_N = 1'b1;

        // Basic draw: x=16, MSB=F0, LSB=0F, palette 2.
        load_record(32'h0210_F00F);
        for (int x = 0; x < 340; x++) begin
            @(negedge PPU_SLOW_CLOCK);
            bus.PIXEL_X = 10'(x);
            #1;
            exp_valid = (x >= 16) && (x <= 23);
            exp_pal   = !exp_valid ? 4'h0 : ((x <= 19) ? 4'hA : 4'h9);
            check($sformatf("basic_valid_x%0d", x), {3'b000, bus.VALID}, {3'b000, exp_valid});
            check($sformatf("basic_pal_x%0d", x), bus.PAL_COLOUR, exp_pal);
        end

        // Transparency: only LSB bits 7 and 0 set, palette 3.
        load_record(32'h0300_0081);
        for (int x = 0; x < 16; x++) begin
            @(negedge PPU_SLOW_CLOCK);
            bus.PIXEL_X = 10'(x);
            #1;
            exp_valid = (x == 0) || (x == 7);
            exp_pal   = exp_valid ? 4'hD : 4'h0;
            check($sformatf("transp_valid_x%0d", x), {3'b000, bus.VALID}, {3'b000, exp_valid});
            check($sformatf("transp_pal_x%0d", x), bus.PAL_COLOUR, exp_pal);
        end

        // Horizontal flip of the basic record.
        load_record(32'h4210_F00F);
        for (int x = 12; x < 28; x++) begin
            @(negedge PPU_SLOW_CLOCK);
            bus.PIXEL_X = 10'(x);
            #1;
            exp_valid = (x >= 16) && (x <= 23);
            exp_pal   = !exp_valid ? 4'h0 : ((x <= 19) ? 4'h9 : 4'hA);
            check($sformatf("hflip_valid_x%0d", x), {3'b000, bus.VALID}, {3'b000, exp_valid});
            check($sformatf("hflip_pal_x%0d", x), bus.PAL_COLOUR, exp_pal);
        end

        // Right-edge clip: x=252, solid pattern, palette 1.
        load_record(32'h01FC_FFFF);
        for (int x = 0; x < 340; x++) begin
            @(negedge PPU_SLOW_CLOCK);
            bus.PIXEL_X = 10'(x);
            #1;
            exp_valid = (x >= 252) && (x <= 255);
            exp_pal   = exp_valid ? 4'h7 : 4'h0;
            check($sformatf("clip_valid_x%0d", x), {3'b000, bus.VALID}, {3'b000, exp_valid});
            check($sformatf("clip_pal_x%0d", x), bus.PAL_COLOUR, exp_pal);
        end

        // DRAW_EN drop: still visible until the next edge, gone after it.
        @(negedge PPU_SLOW_CLOCK);
        bus.PIXEL_X = 10'd253;
        #1;
        check("drop_before_edge", {3'b000, bus.VALID}, 4'h1);
        bus.DRAW_EN = 1'b0;
        #1;
        check("drop_same_cycle", {3'b000, bus.VALID}, 4'h1);
        @(negedge PPU_SLOW_CLOCK);
        #1;
        check("drop_after_edge", {3'b000, bus.VALID}, 4'h0);
        check("drop_after_edge_pal", bus.PAL_COLOUR, 4'h0);

        // Reload at x=0x40 while drawing column 0x40; only bit 6 is opaque.
        @(negedge PPU_SLOW_CLOCK);
        bus.SPR_BUF = 32'h0240_0040;
        bus.LOAD    = 1'b1;
        bus.DRAW_EN = 1'b1;
        bus.PIXEL_X = 10'h040;
        #1;
        check("reload_before_edge", {3'b000, bus.VALID}, 4'h0);
        @(posedge PPU_SLOW_CLOCK);
        #1;
        check("reload_col40", {3'b000, bus.VALID}, 4'h0);
        @(negedge PPU_SLOW_CLOCK);
        bus.LOAD    = 1'b0;
        bus.PIXEL_X = 10'h041;
        #1;
        check("reload_col41_valid", {3'b000, bus.VALID}, 4'h1);
        check("reload_col41_pal", bus.PAL_COLOUR, 4'h9);
        bus.PIXEL_X = 10'h042;
        #1;
        check("reload_col42_valid", {3'b000, bus.VALID}, 4'h0);

        // Asynchronous reset mid-draw, away from any clock edge.
        bus.PIXEL_X = 10'h041;
        #1;
        check("prereset_valid", {3'b000, bus.VALID}, 4'h1);
        RST_N = 1'b0;
        #1;
        check("async_reset_valid", {3'b000, bus.VALID}, 4'h0);
        check("async_reset_pal", bus.PAL_COLOUR, 4'h0);
        bus.DRAW_EN = 1'b0;
        @(negedge PPU_SLOW_CLOCK);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge PPU_SLOW_CLOCK);
            #1;
            check("post_reset_valid", {3'b000, bus.VALID}, 4'h0);
            check("post_reset_pal", bus.PAL_COLOUR, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
